lsu_dmem_master: RTL and testbench

//  Initiator side of the data-memory port. Accepts one load/store at a time from the

---
 rtl/lsu_dmem_master_if.sv | 50 +++++
 rtl/lsu_dmem_master.sv | 156 +++++++++++++++
 tb/tb_lsu_dmem_master.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_dmem_master_if.sv
// ---------------------------------------------------------------------------
// lsu_dmem_master_if
//   Signal bundle between the core's MEM stage, the load/store unit and the
//   data-memory blackbox.
//
//   master modport : the load/store unit (lsu_dmem_master)
//   slave  modport : its environment (MEM stage on the request/response side,
//                    memory blackbox on the dmem_* side)
//
//   Request  : req_valid, req_ready, req_wen, req_size, req_unsigned,
//              req_addr, req_wdata
//   Response : resp_valid, resp_rdata, resp_misalign
//   Memory   : dmem_en, dmem_addr, dmem_rdata, dmem_wen, dmem_wdata, dmem_wmask
// ---------------------------------------------------------------------------
interface lsu_dmem_master_if;
    localparam int XLEN = 64;

    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [1:0]      req_size;
    logic            req_unsigned;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_misalign;

    logic            dmem_en;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_rdata;
    logic            dmem_wen;
    logic [XLEN-1:0] dmem_wdata;
    logic [7:0]      dmem_wmask;

    modport master (
        input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        input  dmem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misalign,
        output dmem_en, dmem_addr, dmem_wen, dmem_wdata, dmem_wmask
    );

    modport slave (
        output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
        output dmem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misalign,
        input  dmem_en, dmem_addr, dmem_wen, dmem_wdata, dmem_wmask
    );
endinterface

// File: rtl/lsu_dmem_master.sv
// ---------------------------------------------------------------------------
// lsu_dmem_master
//   Initiator side of the data-memory port. Takes one load/store at a time
//   from the MEM stage, places store data into byte lanes with a byte mask,
//   extracts and sign/zero-extends load data, and reports misaligned accesses
//   without touching memory.
//
//   Ports
//     clk  in  core clock, all state updates on posedge
//     rst  in  synchronous active-high reset
//     bus  lsu_dmem_master_if.master
//          req_*  : one request, accepted while req_ready (IDLE)
//          resp_* : resp_valid pulses one cycle per finished request
//          dmem_* : 8-byte-aligned word port to the memory blackbox
//
//   Timing: fire in cycle N -> resp_valid in N+2 (aligned) or N+1
//   (misaligned); one request every 3 cycles at best.
// ---------------------------------------------------------------------------
module lsu_dmem_master (
    input  logic                 clk,
    input  logic                 rst,
    lsu_dmem_master_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic        fire;
    logic        misalign;
    logic        access_live;

    // Captured request
    logic        wen_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [2:0]  off_q;
    logic        misalign_q;
    logic [63:0] addr_q;      // already 8-byte aligned
    logic [63:0] wdata_q;     // already shifted into byte lanes
    logic [7:0]  mask_q;
    logic [63:0] rdata_q;

    // Pick the addressed bytes out of the memory word and extend them.
    function automatic logic [63:0] load_extend(
        input logic [63:0] word,
        input logic [2:0]  off,
        input logic [1:0]  size,
        input logic        is_unsigned
    );
        logic [63:0] raw;
        raw = word >> {off, 3'b000};
        case (size)
            2'd0:    load_extend = is_unsigned ? {56'd0, raw[7:0]}
                                               : {{56{raw[7]}}, raw[7:0]};
            2'd1:    load_extend = is_unsigned ? {48'd0, raw[15:0]}
                                               : {{48{raw[15]}}, raw[15:0]};
            2'd2:    load_extend = is_unsigned ? {32'd0, raw[31:0]}
                                               : {{32{raw[31]}}, raw[31:0]};
            default: load_extend = raw;
        endcase
    endfunction

    function automatic logic [7:0] base_mask(input logic [1:0] size);
        case (size)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    endfunction

    assign bus.req_ready = (state_q == IDLE) & ~rst;
    assign fire          = bus.req_valid & bus.req_ready;

    always_comb begin
        misalign = 1'b0;
        case (bus.req_size)
            2'd1:    misalign = bus.req_addr[0];
            2'd2:    misalign = |bus.req_addr[1:0];
            2'd3:    misalign = |bus.req_addr[2:0];
            default: misalign = 1'b0;
        endcase
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fire) state_d = misalign ? RESP : ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset in the ACCESS cycle must kill the memory strobe immediately so
    // the blackbox commits nothing on that edge.
    assign access_live    = (state_q == ACCESS) & ~rst;
    assign bus.dmem_en    = access_live & ~wen_q;
    assign bus.dmem_wen   = access_live &  wen_q;
    assign bus.dmem_wmask = bus.dmem_wen ? mask_q : 8'h00;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;

    assign bus.resp_valid    = (state_q == RESP);
    assign bus.resp_misalign = (state_q == RESP) & misalign_q;
    assign bus.resp_rdata    = rdata_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    // NOTE: the datapath registers are reset too, not just the FSM, because
    // they drive dmem_addr/dmem_wdata/resp_rdata directly and must read 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wen_q      <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'd0;
            off_q      <= 3'd0;
            misalign_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state_q <= state_d;

            if (fire) begin
                wen_q      <= bus.req_wen;
                unsigned_q <= bus.req_unsigned;
                size_q     <= bus.req_size;
                off_q      <= bus.req_addr[2:0];
                misalign_q <= misalign;
                addr_q     <= {bus.req_addr[63:3], 3'b000};
                wdata_q    <= bus.req_wdata << {bus.req_addr[2:0], 3'b000};
                mask_q     <= base_mask(bus.req_size) << bus.req_addr[2:0];
                if (misalign) begin
                    rdata_q <= '0;
                end
            end

            // dmem_rdata is valid during ACCESS; capture the extended result.
            if (state_q == ACCESS) begin
                rdata_q <= wen_q ? 64'd0
                                 : load_extend(bus.dmem_rdata, off_q, size_q, unsigned_q);
            end
        end
    end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_dmem_master
//   Bench for lsu_dmem_master: memory blackbox model, hand-written vector
//   table, back-to-back and reset-in-ACCESS sequences, then random requests
//   checked against a byte-addressed reference memory.
// ---------------------------------------------------------------------------
module tb_lsu_dmem_master;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_dmem_master_if bus ();

    lsu_dmem_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // ---------------- memory blackbox: 32 words at BASE ----------------
    logic [63:0] bb_mem [32] = '{default: 64'h0};

    assign bus.dmem_rdata = bus.dmem_en ? bb_mem[bus.dmem_addr[7:3]] : 64'h0;

    always @(posedge clk) begin
        if (bus.dmem_wen) begin
            for (int b = 0; b < 8; b++) begin
                if (bus.dmem_wmask[b])
                    bb_mem[bus.dmem_addr[7:3]][8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
            end
        end
    end

    // ---------------- fire log for throughput checks ----------------
    int cyc = 0;
    int fire_cyc [$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.req_valid && bus.req_ready) fire_cyc.push_back(cyc);
    end

    // ---------------- reference model: byte memory ----------------
    logic [7:0] ref_mem [256] = '{default: 8'h00};

    function automatic logic ref_misalign(input logic [1:0] size, input logic [63:0] addr);
        return (addr % (64'd1 << size)) != 64'd0;
    endfunction

    function automatic logic [63:0] ref_load(input logic [1:0] size, input logic uns,
                                             input logic [63:0] addr);
        int n;
        logic [63:0] v;
        n = 1 << size;
        v = 64'd0;
        for (int i = 0; i < n; i++)
            v = v | (64'(ref_mem[int'(addr[7:0]) + i]) << (8 * i));
        if (!uns && n < 8 && v[8*n-1])
            v = v - (64'd1 << (8 * n));
        return v;
    endfunction

    task automatic ref_apply(input logic wen, input logic [1:0] size,
                             input logic [63:0] addr, input logic [63:0] wdata);
        if (wen && !ref_misalign(size, addr)) begin
            for (int i = 0; i < (1 << size); i++)
                ref_mem[int'(addr[7:0]) + i] = wdata[8*i +: 8];
        end
    endtask

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        int          lat;
        logic        mis;
        logic [63:0] rdata;
        logic        saw_en;
        logic        saw_wen;
        logic [7:0]  mask;
        logic [63:0] lanes;
        logic [63:0] daddr;
        logic        held_ok;
    } res_t;

    // Issue one request from IDLE and observe it to completion.
    task automatic run_req(input logic wen, input logic [1:0] size, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wdata,
                           output res_t r);
        int guard;
        r.lat = 0; r.mis = 1'b0; r.rdata = '0; r.saw_en = 1'b0; r.saw_wen = 1'b0;
        r.mask = '0; r.lanes = '0; r.daddr = '0; r.held_ok = 1'b0;
        guard = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        bus.req_valid    = 1'b1;
        bus.req_wen      = wen;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (bus.dmem_en) begin
                r.saw_en = 1'b1;
                r.daddr  = bus.dmem_addr;
            end
            if (bus.dmem_wen) begin
                r.saw_wen = 1'b1;
                r.mask    = bus.dmem_wmask;
                r.lanes   = bus.dmem_wdata;
                r.daddr   = bus.dmem_addr;
            end
            if (bus.resp_valid) begin
                r.lat   = k;
                r.mis   = bus.resp_misalign;
                r.rdata = bus.resp_rdata;
                break;
            end
        end
        if (r.lat != 0) begin
            @(negedge clk);
            r.held_ok = !bus.resp_valid && (bus.resp_rdata == r.rdata) && bus.req_ready;
        end
    endtask

    task automatic check_result(input string tag, input logic wen, input logic [63:0] addr,
                                input res_t r, input logic exp_mis, input logic [63:0] exp_rdata,
                                input logic [7:0] exp_mask, input logic [63:0] exp_lanes);
        logic [63:0] lane_bits;
        check({tag, "_latency"}, 64'(r.lat), exp_mis ? 64'd1 : 64'd2);
        check({tag, "_misalign"}, 64'(r.mis), 64'(exp_mis));
        check({tag, "_rdata"}, r.rdata, exp_rdata);
        check({tag, "_one_cycle_hold"}, 64'(r.held_ok), 64'd1);
        if (exp_mis) begin
            check({tag, "_no_mem_access"}, {62'd0, r.saw_en, r.saw_wen}, 64'd0);
        end else if (wen) begin
            check({tag, "_store_strobes"}, {62'd0, r.saw_en, r.saw_wen}, 64'd1);
            check({tag, "_wmask"}, 64'(r.mask), 64'(exp_mask));
            lane_bits = '0;
            for (int b = 0; b < 8; b++) lane_bits[8*b +: 8] = {8{exp_mask[b]}};
            check({tag, "_wdata_lanes"}, r.lanes & lane_bits, exp_lanes);
            check({tag, "_daddr"}, r.daddr, addr & ~64'h7);
        end else begin
            check({tag, "_load_strobes"}, {62'd0, r.saw_en, r.saw_wen}, 64'd2);
            check({tag, "_daddr"}, r.daddr, addr & ~64'h7);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        wen;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        exp_mis;
        logic [63:0] exp_rdata;
        logic [7:0]  exp_mask;
        logic [63:0] exp_lanes;
    } vec_t;

    function automatic vec_t mk(input logic wen, input logic [1:0] size, input logic uns,
                                input logic [63:0] addr, input logic [63:0] wdata,
                                input logic exp_mis, input logic [63:0] exp_rdata,
                                input logic [7:0] exp_mask, input logic [63:0] exp_lanes);
        vec_t v;
        v.wen = wen; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.exp_mis = exp_mis; v.exp_rdata = exp_rdata;
        v.exp_mask = exp_mask; v.exp_lanes = exp_lanes;
        return v;
    endfunction

    vec_t vecs [17];
    res_t r;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        //                wen  sz   uns  addr          wdata                      mis  rdata                      mask   lanes
        vecs[0]  = mk(1'b1, 2'd0, 1'b0, BASE + 64'h5, 64'h0000_0000_0000_00AB, 1'b0, 64'h0,                   8'h20, 64'h0000_AB00_0000_0000);
        vecs[1]  = mk(1'b1, 2'd3, 1'b0, BASE + 64'h0, 64'h8765_4321_0000_0000, 1'b0, 64'h0,                   8'hFF, 64'h8765_4321_0000_0000);
        vecs[2]  = mk(1'b0, 2'd2, 1'b0, BASE + 64'h4, 64'h0,                   1'b0, 64'hFFFF_FFFF_8765_4321, 8'h00, 64'h0);
        vecs[3]  = mk(1'b0, 2'd2, 1'b1, BASE + 64'h4, 64'h0,                   1'b0, 64'h0000_0000_8765_4321, 8'h00, 64'h0);
        vecs[4]  = mk(1'b0, 2'd0, 1'b0, BASE + 64'h7, 64'h0,                   1'b0, 64'hFFFF_FFFF_FFFF_FF87, 8'h00, 64'h0);
        vecs[5]  = mk(1'b0, 2'd1, 1'b1, BASE + 64'h6, 64'h0,                   1'b0, 64'h0000_0000_0000_8765, 8'h00, 64'h0);
        vecs[6]  = mk(1'b0, 2'd3, 1'b0, BASE + 64'h0, 64'h0,                   1'b0, 64'h8765_4321_0000_0000, 8'h00, 64'h0);
        vecs[7]  = mk(1'b0, 2'd1, 1'b0, BASE + 64'h3, 64'h0,                   1'b1, 64'h0,                   8'h00, 64'h0);
        vecs[8]  = mk(1'b1, 2'd2, 1'b0, BASE + 64'h2, 64'hFFFF_FFFF,           1'b1, 64'h0,                   8'h00, 64'h0);
        vecs[9]  = mk(1'b0, 2'd3, 1'b1, BASE + 64'h4, 64'h0,                   1'b1, 64'h0,                   8'h00, 64'h0);
        vecs[10] = mk(1'b0, 2'd3, 1'b0, BASE + 64'h0, 64'h0,                   1'b0, 64'h8765_4321_0000_0000, 8'h00, 64'h0);
        vecs[11] = mk(1'b1, 2'd1, 1'b0, BASE + 64'hA, 64'h0000_0000_1234_BEEF, 1'b0, 64'h0,                   8'h0C, 64'h0000_0000_BEEF_0000);
        vecs[12] = mk(1'b0, 2'd1, 1'b0, BASE + 64'hA, 64'h0,                   1'b0, 64'hFFFF_FFFF_FFFF_BEEF, 8'h00, 64'h0);
        vecs[13] = mk(1'b0, 2'd0, 1'b1, BASE + 64'hB, 64'h0,                   1'b0, 64'h0000_0000_0000_00BE, 8'h00, 64'h0);
        vecs[14] = mk(1'b0, 2'd2, 1'b1, BASE + 64'h8, 64'h0,                   1'b0, 64'h0000_0000_BEEF_0000, 8'h00, 64'h0);
        vecs[15] = mk(1'b0, 2'd0, 1'b0, BASE + 64'h5, 64'h0,                   1'b0, 64'h0000_0000_0000_0043, 8'h00, 64'h0);
        vecs[16] = mk(1'b0, 2'd3, 1'b0, BASE + 64'h10, 64'h0,                  1'b0, 64'h0,                   8'h00, 64'h0);

        bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

        // ---- reset: hold two cycles, everything reads 0 ----
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready",     64'(bus.req_ready), 64'd0);
        check("rst_resp_valid",    64'(bus.resp_valid), 64'd0);
        check("rst_resp_misalign", 64'(bus.resp_misalign), 64'd0);
        check("rst_resp_rdata",    bus.resp_rdata, 64'd0);
        check("rst_dmem_strobes",  {62'd0, bus.dmem_en, bus.dmem_wen}, 64'd0);
        check("rst_dmem_addr",     bus.dmem_addr, 64'd0);
        check("rst_dmem_wdata",    bus.dmem_wdata, 64'd0);
        check("rst_dmem_wmask",    64'(bus.dmem_wmask), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 64'(bus.req_ready), 64'd1);

        // ---- directed table ----
        foreach (vecs[i]) begin
            run_req(vecs[i].wen, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, r);
            check_result($sformatf("vec%0d", i), vecs[i].wen, vecs[i].addr, r,
                         vecs[i].exp_mis, vecs[i].exp_rdata, vecs[i].exp_mask, vecs[i].exp_lanes);
            ref_apply(vecs[i].wen, vecs[i].size, vecs[i].addr, vecs[i].wdata);
        end

        // ---- back-to-back: req_valid held through a store then a load ----
        begin
            int guard;
            logic got_resp;
            logic [63:0] load_val;
            @(negedge clk);
            fire_cyc.delete();
            bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_size = 2'd3;
            bus.req_unsigned = 1'b0; bus.req_addr = BASE + 64'h20;
            bus.req_wdata = 64'h0123_4567_89AB_CDEF;
            guard = 0;
            while (fire_cyc.size() < 1 && guard < 10) begin
                @(posedge clk); #1; guard++;
            end
            bus.req_wen = 1'b0;   // same address, now a load
            guard = 0;
            while (fire_cyc.size() < 2 && guard < 10) begin
                @(posedge clk); #1; guard++;
            end
            bus.req_valid = 1'b0;
            check("b2b_two_fires", 64'(fire_cyc.size()), 64'd2);
            if (fire_cyc.size() >= 2)
                check("b2b_fire_spacing", 64'(fire_cyc[1] - fire_cyc[0]), 64'd3);
            got_resp = 1'b0;
            load_val = '0;
            for (int k = 0; k < 4 && !got_resp; k++) begin
                @(negedge clk);
                if (bus.resp_valid) begin
                    got_resp = 1'b1;
                    load_val = bus.resp_rdata;
                end
            end
            check("b2b_load_resp", 64'(got_resp), 64'd1);
            check("b2b_load_value", load_val, 64'h0123_4567_89AB_CDEF);
            ref_apply(1'b1, 2'd3, BASE + 64'h20, 64'h0123_4567_89AB_CDEF);
        end

        // ---- reset during the ACCESS cycle of a store ----
        begin
            int guard;
            int resp_seen;
            guard = 0;
            @(negedge clk);
            while (!bus.req_ready && guard < 10) begin
                @(negedge clk); guard++;
            end
            bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_size = 2'd3;
            bus.req_unsigned = 1'b0; bus.req_addr = BASE + 64'h30;
            bus.req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            check("rst_access_wen", 64'(bus.dmem_wen), 64'd0);
            check("rst_access_en",  64'(bus.dmem_en), 64'd0);
            @(posedge clk);
            #1 rst = 1'b0;
            resp_seen = 0;
            repeat (4) begin
                @(negedge clk);
                if (bus.resp_valid) resp_seen++;
            end
            check("rst_access_no_resp", 64'(resp_seen), 64'd0);
            check("rst_access_mem_word", bb_mem[6], 64'd0);
            run_req(1'b0, 2'd3, 1'b0, BASE + 64'h30, 64'd0, r);
            check_result("rst_access_readback", 1'b0, BASE + 64'h30, r, 1'b0, 64'd0, 8'h00, 64'd0);
        end

        // ---- random requests against the byte-memory model ----
        for (int t = 0; t < 200; t++) begin
            logic        wen, uns, mis;
            logic [1:0]  size;
            logic [63:0] addr, wdata, exp_rdata, exp_lanes;
            logic [7:0]  exp_mask;
            int          off;
            wen   = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 3));
            addr  = BASE + 64'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << size) - 64'd1);
            wdata = {$urandom, $urandom};
            mis   = ref_misalign(size, addr);
            exp_rdata = (mis || wen) ? 64'd0 : ref_load(size, uns, addr);
            off = int'(addr[2:0]);
            exp_mask  = '0;
            exp_lanes = '0;
            if (!mis) begin
                for (int i = 0; i < (1 << size); i++) begin
                    exp_mask[off + i] = 1'b1;
                    exp_lanes[8*(off + i) +: 8] = wdata[8*i +: 8];
                end
            end
            run_req(wen, size, uns, addr, wdata, r);
            check_result($sformatf("rand%0d", t), wen, addr, r, mis, exp_rdata, exp_mask, exp_lanes);
            ref_apply(wen, size, addr, wdata);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
